// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I funct3 codes,
// data_mem byte_size encodings and the access-sequencing FSM states.
package lsu_pkg;

  // RV32I load/store funct3 codes (stores use only the signed-looking ones).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // data_mem byte_size encodings.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Access sequencing: accept in IDLE, strobe in ACCESS, extra read
  // latency in WAIT, one-cycle load/exception response in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_decode.sv
// Combinational funct3 decoder: derives data_mem size/extension controls and
// flags unsupported encodings and misaligned addresses for one request.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       is_store,
  output logic [1:0] byte_size,
  output logic       sign_ext,
  output logic       misalign,
  output logic       illegal
);

  // Size, extension and fault classification of the incoming request.
  always_comb begin
    // NOTE: every output gets a value before the case so no path can leave
    // one unassigned; an unassigned path would infer a latch.
    byte_size = SZ_BYTE;
    sign_ext  = ~funct3[2];
    illegal   = 1'b0;

    case (funct3)
      F3_B, F3_BU: byte_size = SZ_BYTE;
      F3_H, F3_HU: byte_size = SZ_HALF;
      F3_W:        byte_size = SZ_WORD;
      default:     byte_size = SZ_BYTE;
    endcase

    // Stores have no unsigned forms; loads reject 011/110/111.
    if (is_store)
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    // Only meaningful when the encoding is legal; the top gives illegal priority.
    misalign = ((byte_size == SZ_HALF) && addr_lo[0]) ||
               ((byte_size == SZ_WORD) && (addr_lo != 2'b00));
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of data_mem. Accepts one request at a
// time, decodes it, runs a single store strobe or a (possibly multi-cycle)
// read, and returns load data or an exception as a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 0,
  parameter int ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              misalign_exc,
  output logic              illegal_exc,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_sign_ext,
  output logic [1:0]        mem_byte_size,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  // WAIT-cycle counter: counts 0 .. READ_LATENCY-1.
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam bit ZERO_LAT = (READ_LATENCY == 0);

  lsu_state_t        state;
  lsu_state_t        next_state;

  logic              is_store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              misalign_q;
  logic              illegal_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        dec_size;
  logic              dec_sext;
  logic              dec_misalign;
  logic              dec_illegal;

  logic              accept;
  logic              wait_done;
  logic              capture;

  lsu_decode u_decode (
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .is_store  (req_is_store),
    .byte_size (dec_size),
    .sign_ext  (dec_sext),
    .misalign  (dec_misalign),
    .illegal   (dec_illegal)
  );

  assign accept    = (state == IDLE) && req_valid;
  assign wait_done = (cnt_q == LAST_CNT);
  // Read data is taken on the last cycle mem_read is held.
  assign capture   = (ZERO_LAT && (state == ACCESS) && !is_store_q) ||
                     ((state == WAIT) && wait_done);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state, handshake, strobes and response qualifiers.
  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    resp_valid   = 1'b0;
    misalign_exc = 1'b0;
    illegal_exc  = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          next_state = (dec_illegal || dec_misalign) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (is_store_q) begin
          mem_write  = 1'b1;
          next_state = IDLE;
        end else begin
          mem_read   = 1'b1;
          next_state = ZERO_LAT ? RESP : WAIT;
        end
      end
      WAIT: begin
        mem_read = 1'b1;
        if (wait_done) next_state = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        illegal_exc  = illegal_q;
        misalign_exc = misalign_q && !illegal_q;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latches, read-data capture and WAIT counter.
  always_ff @(posedge clock) begin
    // NOTE: the datapath registers are reset too, because they drive the
    // mem_* and resp_* outputs directly and those must read zero out of reset.
    if (reset) begin
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      size_q     <= SZ_BYTE;
      sext_q     <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        is_store_q <= req_is_store;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
        size_q     <= dec_size;
        sext_q     <= dec_sext;
        misalign_q <= dec_misalign;
        illegal_q  <= dec_illegal;
        rdata_q    <= '0;
      end
      if (capture) rdata_q <= mem_read_data;
      if (state == ACCESS)    cnt_q <= '0;
      else if (state == WAIT) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign mem_address    = addr_q;
  assign mem_byte_size  = size_q;
  assign mem_sign_ext   = sext_q;
  assign mem_write_data = wdata_q;
  assign resp_rd        = rd_q;
  assign resp_data      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with combinational reads and one
// with two cycles of read latency, each behind its own byte-array data_mem
// stand-in. Expected results come from an architectural model of RV32I
// loads/stores kept in the bench.
module tb_load_store_unit;

  localparam int RL2 = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Per-instance signals (suffix 0: READ_LATENCY=0, suffix 2: READ_LATENCY=2).
  logic        valid0, ready0, rv0, mis0, ill0, mw0, mr0, sx0;
  logic [4:0]  rd0;
  logic [1:0]  sz0;
  logic [31:0] data0, ma0, mwd0, mrd0;
  logic        valid2, ready2, rv2, mis2, ill2, mw2, mr2, sx2;
  logic [4:0]  rd2;
  logic [1:0]  sz2;
  logic [31:0] data2, ma2, mwd2, mrd2;

  assign valid0 = req_valid && !sel;
  assign valid2 = req_valid && sel;

  load_store_unit #(.READ_LATENCY(0), .ADDR_W(32)) dut0 (
    .clock(clock), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(rv0), .resp_rd(rd0),
    .resp_data(data0), .misalign_exc(mis0), .illegal_exc(ill0),
    .mem_write(mw0), .mem_read(mr0), .mem_sign_ext(sx0), .mem_byte_size(sz0),
    .mem_address(ma0), .mem_write_data(mwd0), .mem_read_data(mrd0)
  );

  load_store_unit #(.READ_LATENCY(RL2), .ADDR_W(32)) dut2 (
    .clock(clock), .reset(reset), .req_valid(valid2), .req_ready(ready2),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(rv2), .resp_rd(rd2),
    .resp_data(data2), .misalign_exc(mis2), .illegal_exc(ill2),
    .mem_write(mw2), .mem_read(mr2), .mem_sign_ext(sx2), .mem_byte_size(sz2),
    .mem_address(ma2), .mem_write_data(mwd2), .mem_read_data(mrd2)
  );

  // Outputs of the instance currently under test.
  logic        o_ready, o_rv, o_mis, o_ill, o_mw, o_mr, o_sx;
  logic [4:0]  o_rd;
  logic [1:0]  o_sz;
  logic [31:0] o_data, o_ma, o_mwd;
  assign o_ready = sel ? ready2 : ready0;
  assign o_rv    = sel ? rv2    : rv0;
  assign o_mis   = sel ? mis2   : mis0;
  assign o_ill   = sel ? ill2   : ill0;
  assign o_mw    = sel ? mw2    : mw0;
  assign o_mr    = sel ? mr2    : mr0;
  assign o_sx    = sel ? sx2    : sx0;
  assign o_rd    = sel ? rd2    : rd0;
  assign o_sz    = sel ? sz2    : sz0;
  assign o_data  = sel ? data2  : data0;
  assign o_ma    = sel ? ma2    : ma0;
  assign o_mwd   = sel ? mwd2   : mwd0;

  // ---------------- data_mem stand-ins (256 bytes, little-endian) ----------
  bit [7:0]  mem0 [256];
  bit [7:0]  mem2 [256];
  logic [7:0] a0, a2;
  int        rcnt2 = 0;
  assign a0 = ma0[7:0];
  assign a2 = ma2[7:0];

  function automatic logic [31:0] fmt(input logic [7:0] b0, b1, b2, b3,
                                      input logic [1:0] sz, input logic sx);
    case (sz)
      2'b00:   fmt = {{24{sx & b0[7]}}, b0};
      2'b01:   fmt = {{16{sx & b1[7]}}, b1, b0};
      default: fmt = {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clock) begin
    if (mw0) begin
      mem0[a0] <= mwd0[7:0];
      if (sz0 != 2'b00) mem0[a0 + 8'd1] <= mwd0[15:8];
      if (sz0 == 2'b10) begin
        mem0[a0 + 8'd2] <= mwd0[23:16];
        mem0[a0 + 8'd3] <= mwd0[31:24];
      end
    end
    if (mw2) begin
      mem2[a2] <= mwd2[7:0];
      if (sz2 != 2'b00) mem2[a2 + 8'd1] <= mwd2[15:8];
      if (sz2 == 2'b10) begin
        mem2[a2 + 8'd2] <= mwd2[23:16];
        mem2[a2 + 8'd3] <= mwd2[31:24];
      end
    end
    rcnt2 <= mr2 ? rcnt2 + 1 : 0;
  end

  // Read data is garbage except while the read is valid.
  always_comb begin
    mrd0 = 32'hBAD0BAD0;
    mrd2 = 32'hBAD0BAD0;
    if (mr0)
      mrd0 = fmt(mem0[a0], mem0[a0 + 8'd1], mem0[a0 + 8'd2], mem0[a0 + 8'd3], sz0, sx0);
    if (mr2 && rcnt2 >= RL2)
      mrd2 = fmt(mem2[a2], mem2[a2 + 8'd1], mem2[a2 + 8'd2], mem2[a2 + 8'd3], sz2, sx2);
  end

  // ---------------- architectural reference model --------------------------
  bit [7:0] ref_mem [2][256];

  function automatic bit ref_illegal(input bit st, input logic [2:0] f3);
    if (st) return (f3 >= 3'd4) || (f3 == 3'd3);
    return (f3 == 3'd3) || (f3 >= 3'd6);
  endfunction

  function automatic int ref_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] ref_size(input logic [2:0] f3);
    case (ref_bytes(f3))
      1:       return 2'b00;
      2:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic bit ref_misalign(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % ref_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int s, input logic [31:0] addr,
                                           input logic [2:0] f3);
    logic [31:0] v;
    int n;
    n = ref_bytes(f3);
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[s][(int'(addr[7:0]) + i) % 256]) << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input int s, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < ref_bytes(f3); i++)
      ref_mem[s][(int'(addr[7:0]) + i) % 256] = wd[8*i +: 8];
  endtask

  // ---------------- stimulus driver ----------------------------------------
  typedef struct {
    int          lat;        // cycle (after accept) resp_valid first seen, -1 none
    int          ready_lat;  // cycle req_ready came back
    int          n_wr;
    int          n_rd;
    int          n_resp;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        ill;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obs_t;

  // Issues one request on the selected instance and records what it does.
  // Entered and left just after a falling edge.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input bit hold,
                       output obs_t o);
    int w;
    o = '{lat: -1, ready_lat: -1, n_wr: 0, n_rd: 0, n_resp: 0, rd: '0, data: '0,
          mis: 1'b0, ill: 1'b0, sz: '0, sx: 1'b0, addr: '0, wdata: '0};
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
    w = 0;
    while (!o_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!o_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", o_ready, w);
      req_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (o_mw) begin
        o.n_wr++; o.sz = o_sz; o.addr = o_ma; o.wdata = o_mwd;
      end
      if (o_mr) begin
        o.n_rd++; o.sz = o_sz; o.sx = o_sx; o.addr = o_ma;
      end
      if (o_rv) begin
        o.n_resp++;
        if (o.lat < 0) o.lat = k;
        o.rd = o_rd; o.data = o_data; o.mis = o_mis; o.ill = o_ill;
      end
      if (!hold) req_valid = 1'b0;
      if (o_ready) begin
        o.ready_lat = k;
        break;
      end
    end
    if (o.ready_lat < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: req_ready never returned, required within 20 cycles");
    end
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; sel = 1'b0;
    req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({ready0, rv0, mw0, mr0, sx0, mis0, ill0, sz0} !== 9'b1_000000_00) begin
      bad++; $display("FAIL reset_ctl0: got %b required 100000000",
                      {ready0, rv0, mw0, mr0, sx0, mis0, ill0, sz0});
    end
    total++;
    if ({ma0, mwd0, data0, rd0} !== 101'd0) begin
      bad++; $display("FAIL reset_bus0: addr=%h wdata=%h data=%h rd=%0d required all 0",
                      ma0, mwd0, data0, rd0);
    end
    total++;
    if ({ready2, rv2, mw2, mr2, sx2, mis2, ill2, sz2} !== 9'b1_000000_00) begin
      bad++; $display("FAIL reset_ctl2: got %b required 100000000",
                      {ready2, rv2, mw2, mr2, sx2, mis2, ill2, sz2});
    end
    total++;
    if ({ma2, mwd2, data2, rd2} !== 101'd0) begin
      bad++; $display("FAIL reset_bus2: addr=%h wdata=%h data=%h rd=%0d required all 0",
                      ma2, mwd2, data2, rd2);
    end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    obs_t o;
    sel = 1'b0;
    do_op(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 5'd0, 1'b0, o);
    ref_store(0, 32'h0, 3'b010, 32'hDEADBEEF);
    total++;
    if (o.n_wr !== 1 || o.n_rd !== 0 || o.n_resp !== 0 || o.ready_lat !== 2) begin
      bad++; $display("FAIL sw_timing: wr=%0d rd=%0d resp=%0d ready_at=%0d required 1 0 0 2",
                      o.n_wr, o.n_rd, o.n_resp, o.ready_lat);
    end
    total++;
    if ({o.sz, o.addr, o.wdata} !== {2'b10, 32'h0, 32'hDEADBEEF}) begin
      bad++; $display("FAIL sw_bus: size=%b addr=%h wdata=%h required 10 0 deadbeef",
                      o.sz, o.addr, o.wdata);
    end
    do_op(1'b0, 3'b010, 32'h0, 32'h0, 5'd5, 1'b0, o);
    total++;
    if (o.lat !== 2 || o.n_resp !== 1 || o.n_rd !== 1 || o.n_wr !== 0) begin
      bad++; $display("FAIL lw_timing: resp_at=%0d resp=%0d rd=%0d wr=%0d required 2 1 1 0",
                      o.lat, o.n_resp, o.n_rd, o.n_wr);
    end
    total++;
    if ({o.rd, o.data, o.mis, o.ill} !== {5'd5, ref_load(0, 32'h0, 3'b010), 2'b00}) begin
      bad++; $display("FAIL lw_resp: rd=%0d data=%h exc=%b%b required 5 deadbeef 00",
                      o.rd, o.data, o.mis, o.ill);
    end
  endtask

  task automatic test_byte_ext();
    obs_t o;
    sel = 1'b0;
    do_op(1'b1, 3'b000, 32'h3, 32'h00000080, 5'd0, 1'b0, o);
    ref_store(0, 32'h3, 3'b000, 32'h00000080);
    total++;
    if (o.n_wr !== 1 || o.sz !== 2'b00) begin
      bad++; $display("FAIL sb: wr=%0d size=%b required 1 00", o.n_wr, o.sz);
    end
    do_op(1'b0, 3'b000, 32'h3, 32'h0, 5'd1, 1'b0, o);
    total++;
    if ({o.rd, o.data, o.sx} !== {5'd1, 32'hFFFFFF80, 1'b1}) begin
      bad++; $display("FAIL lb: rd=%0d data=%h sext=%b required 1 ffffff80 1",
                      o.rd, o.data, o.sx);
    end
    do_op(1'b0, 3'b100, 32'h3, 32'h0, 5'd2, 1'b0, o);
    total++;
    if ({o.rd, o.data, o.sx} !== {5'd2, 32'h00000080, 1'b0}) begin
      bad++; $display("FAIL lbu: rd=%0d data=%h sext=%b required 2 00000080 0",
                      o.rd, o.data, o.sx);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    sel = 1'b0;
    do_op(1'b0, 3'b001, 32'h1, 32'h0, 5'd3, 1'b0, o);
    total++;
    if (o.n_rd + o.n_wr !== 0 || o.lat !== 1 || o.n_resp !== 1 ||
        {o.mis, o.ill, o.data, o.rd} !== {2'b10, 32'h0, 5'd3}) begin
      bad++; $display("FAIL lh_misalign: strobes=%0d resp_at=%0d mis=%b ill=%b data=%h rd=%0d required 0 1 1 0 0 3",
                      o.n_rd + o.n_wr, o.lat, o.mis, o.ill, o.data, o.rd);
    end
    do_op(1'b0, 3'b010, 32'h2, 32'h0, 5'd4, 1'b0, o);
    total++;
    if (o.n_rd + o.n_wr !== 0 || o.lat !== 1 || {o.mis, o.ill, o.data} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL lw_misalign: strobes=%0d resp_at=%0d mis=%b ill=%b data=%h required 0 1 1 0 0",
                      o.n_rd + o.n_wr, o.lat, o.mis, o.ill, o.data);
    end
    do_op(1'b1, 3'b001, 32'h1, 32'h1234, 5'd0, 1'b0, o);
    total++;
    if (o.n_wr !== 0 || o.lat !== 1 || {o.mis, o.ill} !== 2'b10) begin
      bad++; $display("FAIL sh_misalign: wr=%0d resp_at=%0d mis=%b ill=%b required 0 1 1 0",
                      o.n_wr, o.lat, o.mis, o.ill);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    sel = 1'b0;
    do_op(1'b0, 3'b011, 32'h0, 32'h0, 5'd6, 1'b0, o);
    total++;
    if (o.n_rd + o.n_wr !== 0 || o.lat !== 1 || {o.mis, o.ill, o.data} !== {2'b01, 32'h0}) begin
      bad++; $display("FAIL ld_illegal: strobes=%0d resp_at=%0d mis=%b ill=%b data=%h required 0 1 0 1 0",
                      o.n_rd + o.n_wr, o.lat, o.mis, o.ill, o.data);
    end
    do_op(1'b1, 3'b100, 32'h0, 32'h55, 5'd0, 1'b0, o);
    total++;
    if (o.n_wr !== 0 || o.lat !== 1 || {o.mis, o.ill} !== 2'b01) begin
      bad++; $display("FAIL st_illegal: wr=%0d resp_at=%0d mis=%b ill=%b required 0 1 0 1",
                      o.n_wr, o.lat, o.mis, o.ill);
    end
    // Word-sized illegal encoding at an odd address: illegal wins.
    do_op(1'b0, 3'b110, 32'h1, 32'h0, 5'd7, 1'b0, o);
    total++;
    if ({o.mis, o.ill} !== 2'b01) begin
      bad++; $display("FAIL illegal_priority: mis=%b ill=%b required 0 1", o.mis, o.ill);
    end
  endtask

  task automatic test_latency();
    obs_t o;
    sel = 1'b1;
    do_op(1'b1, 3'b010, 32'h8, 32'h12345678, 5'd0, 1'b0, o);
    ref_store(1, 32'h8, 3'b010, 32'h12345678);
    total++;
    if (o.n_wr !== 1 || o.ready_lat !== 2) begin
      bad++; $display("FAIL sw_lat2: wr=%0d ready_at=%0d required 1 2", o.n_wr, o.ready_lat);
    end
    // req_valid stays high across the whole load.
    do_op(1'b0, 3'b010, 32'h8, 32'h0, 5'd7, 1'b1, o);
    total++;
    if (o.n_rd !== 3 || o.lat !== 4 || o.ready_lat !== 5 || o.n_resp !== 1) begin
      bad++; $display("FAIL lw_lat2_timing: rd=%0d resp_at=%0d ready_at=%0d resp=%0d required 3 4 5 1",
                      o.n_rd, o.lat, o.ready_lat, o.n_resp);
    end
    total++;
    if ({o.rd, o.data, o.mis, o.ill} !== {5'd7, ref_load(1, 32'h8, 3'b010), 2'b00}) begin
      bad++; $display("FAIL lw_lat2_resp: rd=%0d data=%h exc=%b%b required 7 12345678 00",
                      o.rd, o.data, o.mis, o.ill);
    end
    // The held request is taken in the following IDLE cycle; rd=0 still responds.
    do_op(1'b0, 3'b010, 32'h8, 32'h0, 5'd0, 1'b0, o);
    total++;
    if (o.lat !== 4 || o.n_rd !== 3 || {o.rd, o.data} !== {5'd0, 32'h12345678}) begin
      bad++; $display("FAIL held_req: resp_at=%0d rd_cycles=%0d rd=%0d data=%h required 4 3 0 12345678",
                      o.lat, o.n_rd, o.rd, o.data);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    sel = 1'b1;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h8; req_rd = 5'd9;
    @(negedge clock);          // ACCESS
    req_valid = 1'b0;
    @(negedge clock);          // first WAIT cycle
    total++;
    if ({o_ready, o_mr} !== 2'b01) begin
      bad++; $display("FAIL mid_wait: ready=%b mem_read=%b required 0 1", o_ready, o_mr);
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({o_ready, o_mr, o_rv} !== 3'b100) begin
      bad++; $display("FAIL mid_reset: ready=%b mem_read=%b resp_valid=%b required 1 0 0",
                      o_ready, o_mr, o_rv);
    end
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (o_rv || o_mr) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL aborted_resp: activity cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit st, ill, mis;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_data;
    logic [4:0]  rd;
    int rl, e_lat, e_rdy, e_wr, e_rd, e_resp;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      rl  = (s == 1) ? RL2 : 0;
      for (int n = 0; n < 40; n++) begin
        st   = 1'($urandom_range(0, 1));
        f3   = 3'($urandom_range(0, 7));
        addr = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 15));
        wd   = $urandom;
        rd   = 5'($urandom_range(0, 31));
        ill  = ref_illegal(st, f3);
        mis  = !ill && ref_misalign(f3, addr);
        if (ill || mis) begin
          e_lat = 1; e_rdy = 2; e_wr = 0; e_rd = 0; e_resp = 1; exp_data = '0;
        end else if (st) begin
          e_lat = -1; e_rdy = 2; e_wr = 1; e_rd = 0; e_resp = 0; exp_data = '0;
        end else begin
          e_lat = rl + 2; e_rdy = rl + 3; e_wr = 0; e_rd = rl + 1; e_resp = 1;
          exp_data = ref_load(s, addr, f3);
        end
        do_op(st, f3, addr, wd, rd, 1'b0, o);
        total++;
        if (o.lat !== e_lat || o.ready_lat !== e_rdy || o.n_wr !== e_wr ||
            o.n_rd !== e_rd || o.n_resp !== e_resp) begin
          bad++; $display("FAIL rnd_timing[%0d.%0d] st=%0d f3=%0d addr=%h: resp_at=%0d ready_at=%0d wr=%0d rd=%0d resp=%0d required %0d %0d %0d %0d %0d",
                          s, n, st, f3, addr, o.lat, o.ready_lat, o.n_wr, o.n_rd, o.n_resp,
                          e_lat, e_rdy, e_wr, e_rd, e_resp);
        end
        if (ill || mis || !st) begin
          total++;
          if ({o.rd, o.data, o.mis, o.ill} !== {rd, exp_data, mis, ill}) begin
            bad++; $display("FAIL rnd_resp[%0d.%0d] st=%0d f3=%0d addr=%h: rd=%0d data=%h mis=%b ill=%b required %0d %h %b %b",
                            s, n, st, f3, addr, o.rd, o.data, o.mis, o.ill, rd, exp_data, mis, ill);
          end
        end
        if (!ill && !mis) begin
          total++;
          if (st ? ({o.addr, o.wdata, o.sz} !== {addr, wd, ref_size(f3)})
                 : ({o.addr, o.sz, o.sx} !== {addr, ref_size(f3), !f3[2]})) begin
            bad++; $display("FAIL rnd_bus[%0d.%0d] st=%0d f3=%0d: addr=%h wdata=%h size=%b sext=%b required %h %h %b %b",
                            s, n, st, f3, o.addr, o.wdata, o.sz, o.sx, addr, wd, ref_size(f3), !f3[2]);
          end
          if (st) ref_store(s, addr, f3, wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_ext();
    test_misalign();
    test_illegal();
    test_latency();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of data_mem.
- Accepts one load/store request from the EX/MEM pipeline register via valid/ready.
- Decodes funct3 into data_mem controls (byte_size, sign_ext), checks alignment, sequences the memory access with configurable read latency, and returns load data with the destination register tag.
- Stalls the pipeline (req_ready low) while an access is in flight.

Parameters:
- READ_LATENCY, 0, cycles between the mem_read strobe and valid mem_read_data (0 = combinational read).
- ADDR_W, 32, address width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_W  effective address
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- resp_valid  out  1  one-cycle load/exception response pulse
- resp_rd  out  5  destination tag of response
- resp_data  out  32  load result (already extended by data_mem)
- misalign_exc  out  1  qualified by resp_valid: misaligned address
- illegal_exc  out  1  qualified by resp_valid: unsupported funct3
- mem_write  out  1  to data_mem memwrite
- mem_read  out  1  to data_mem memread
- mem_sign_ext  out  1  to data_mem sign_ext
- mem_byte_size  out  2  to data_mem byte_size: 00 byte, 01 half, 10 word
- mem_address  out  ADDR_W  to data_mem address
- mem_write_data  out  32  to data_mem write_data
- mem_read_data  in  32  from data_mem read_data

Behaviour:
- Clock is clock, reset is reset; reset is synchronous and active-high.
- Reset: state IDLE. req_ready=1. resp_valid, misalign_exc, illegal_exc, mem_write, mem_read, mem_sign_ext = 0. mem_byte_size=00. mem_address, mem_write_data, resp_data = 0. resp_rd=0.
- FSM states: IDLE, ACCESS, WAIT, RESP. req_ready = (state==IDLE).
- Accept on the edge where req_valid && req_ready. At acceptance, latch is_store, funct3, addr, wdata and rd.
- Decode:
  - Byte loads/stores: funct3 000/100 → byte_size 00.
  - Half loads/stores: funct3 001/101 → byte_size 01.
  - Word loads/stores: funct3 010 → byte_size 10.
  - sign_ext = ~funct3[2].
- Illegal funct3: load funct3 011/110/111, or store funct3[2]=1 or 011.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Fault on accept (illegal or misaligned):
  - IDLE→RESP; no memory strobe is ever issued.
  - RESP: resp_valid=1, resp_data=0, exactly one exc flag set; illegal takes priority over misalign.
  - Applies to stores as well.
- Normal accept: IDLE→ACCESS.
  - ACCESS lasts 1 cycle. mem_address, mem_byte_size, mem_sign_ext and mem_write_data are driven from the latches.
  - Store: mem_write=1 for exactly this cycle, then →IDLE. No response is issued. The store takes 2 cycles from accept to the next req_ready.
  - Load, READ_LATENCY=0: mem_read=1. Capture mem_read_data at the end of ACCESS, then →RESP.
  - Load, READ_LATENCY>0: →WAIT. mem_read and address stay held. A counter runs READ_LATENCY cycles. Capture mem_read_data at the end of the last WAIT cycle, then →RESP.
- RESP: resp_valid=1 for exactly 1 cycle with resp_rd = latched rd, then →IDLE. mem_read=0 in RESP.
- Load latency from the accept edge to resp_valid high: READ_LATENCY+2 cycles.
- mem_address and the other mem_* data outputs hold their last value when no strobe is asserted; only the strobes are meaningful.
- Loads with rd=0 still execute and respond.
- Back-to-back: a new request is accepted on the edge after RESP (or after a store's ACCESS). There is no pipelining and no overlap.
- Reset mid-operation (any state): next state IDLE, strobes low, and no response is issued for the aborted request.
- req_* inputs are ignored when not in IDLE.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - byte_size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The FSM state enum.
- Sub-module lsu_decode (combinational): funct3 + addr[1:0] + is_store → byte_size, sign_ext, misalign, illegal.

Test Plan:
- SW 0xDEADBEEF to addr 0x0, then LW rd=5 from 0x0 (READ_LATENCY=0) → mem_write single-cycle pulse with byte_size=10; response at accept+2 with resp_rd=5, resp_data=0xDEADBEEF, no exc.
- SB 0x80 to 0x3, then LB rd=1 / LBU rd=2 from 0x3 → resp_data 0xFFFFFF80 then 0x00000080; mem_sign_ext 1 then 0.
- LH from 0x1 and LW from 0x2 → no mem_read/mem_write ever asserted; resp_valid with misalign_exc=1, resp_data=0 at accept+1.
- Load funct3=3'b011 at 0x0 → illegal_exc=1, misalign_exc=0, no strobe; store funct3=3'b100 → illegal_exc=1.
- READ_LATENCY=2: LW → mem_read high for 3 cycles, resp at accept+4; req_ready low from accept+1 through the RESP cycle; a req_valid held meanwhile is accepted only in IDLE.
- Assert reset during WAIT → next cycle IDLE, req_ready=1, mem_read=0, no resp_valid for the aborted load.
